// File: rtl/mm_tile_sequencer.sv
// mm_tile_sequencer: streams a commanded number of vectors through the 16-lane
// datapath with credit flow control and buffers results in a FIFO.
module mm_tile_sequencer #(
    parameter int N     = 16,
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [CW-1:0]   cmd_count,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW*N-1:0] in_data,
    output logic [DW*N-1:0] mm_vector_input,
    output logic            mm_input_valid,
    input  logic [DW*N-1:0] mm_vector_output,
    input  logic [N-1:0]    mm_add_valid,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW*N-1:0] out_data,
    output logic            out_last,
    output logic            busy,
    output logic            done,
    output logic            err_skew
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
    state_t          r_state, w_next;
    logic [CW-1:0]   r_count, r_issued, r_captured, r_popped;
    logic [AW:0]     r_fcnt;
    logic [AW-1:0]   r_wp, r_rp;
    logic [DW*N-1:0] r_mem [DEPTH];
    logic            w_start, w_in_hs, w_cap, w_skew, w_pop;
    logic [CW:0]     w_credit;
    // Credits cover both results still in the datapath and results parked in the FIFO.
    assign w_credit  = {1'b0, r_issued - r_captured} + (CW+1)'(r_fcnt);
    assign cmd_ready = r_state == S_IDLE;
    assign busy      = r_state != S_IDLE;
    assign in_ready  = r_state == S_ISSUE && r_issued < r_count && w_credit < (CW+1)'(DEPTH);
    assign w_start   = cmd_ready && cmd_valid;
    assign w_in_hs   = in_valid && in_ready;
    assign w_cap     = busy && mm_add_valid == {N{1'b1}};
    assign w_skew    = busy && mm_add_valid != '0 && mm_add_valid != {N{1'b1}};
    assign out_valid = r_fcnt != '0;
    assign out_data  = r_mem[r_rp];
    assign w_pop     = out_valid && out_ready;
    assign out_last  = out_valid && r_popped == r_count - CW'(1);
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = !cmd_valid ? S_IDLE : (cmd_count == '0 ? S_DONE : S_ISSUE);
            S_ISSUE: w_next = r_issued == r_count ? S_DRAIN : S_ISSUE;
            S_DRAIN: w_next = r_popped == r_count ? S_DONE : S_DRAIN;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_count         <= '0;
            r_issued        <= '0;
            r_captured      <= '0;
            r_popped        <= '0;
            r_fcnt          <= '0;
            r_wp            <= '0;
            r_rp            <= '0;
            mm_input_valid  <= 1'b0;
            mm_vector_input <= '0;
            done            <= 1'b0;
            err_skew        <= 1'b0;
        end else begin
            r_state        <= w_next;
            done           <= r_state == S_DONE;
            err_skew       <= err_skew | w_skew;
            mm_input_valid <= w_in_hs;
            if (w_in_hs) mm_vector_input <= in_data;
            if (w_start) begin
                r_count    <= cmd_count;
                r_issued   <= '0;
                r_captured <= '0;
                r_popped   <= '0;
            end else begin
                if (w_in_hs) r_issued <= r_issued + CW'(1);
                if (w_cap) r_captured <= r_captured + CW'(1);
                if (w_pop) r_popped <= r_popped + CW'(1);
            end
            if (w_cap) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_fcnt <= r_fcnt + (AW+1)'(w_cap) - (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_cap) r_mem[r_wp] <= mm_vector_output;
    end
endmodule

// File: doc/mm_tile_sequencer.md
Name: mm_tile_sequencer

Overview:
- Controller that streams a command-specified number of input vectors through the 16-lane matrix-vector datapath.
- Weights on matrix_input are held stable by the weight loader.
- Issues vectors with credit-based flow control, captures results when all 16 lane add_valid bits assert, and buffers results in an internal FIFO toward a valid/ready consumer.
- Sits between the feature-vector stream and the aggregation writer in the MM pipeline.

Parameters:
- N, 16, lanes per vector; fixed at 16 to match the datapath.
- DW, 32, bits per element.
- DEPTH, 8, result FIFO entries and maximum in-flight vectors; power of two, at least 2.
- CW, 16, width of the command vector count.

Ports:
- clk  in  1  Clock.
- rst_n  in  1  Reset; asynchronous, active-low.
- cmd_valid  in  1  Command request.
- cmd_ready  out  1  High only in IDLE.
- cmd_count  in  CW  Number of vectors in the command.
- in_valid  in  1  Input vector valid.
- in_ready  out  1  Input vector accepted when both in_valid and in_ready are high.
- in_data  in  DW*N  Input vector.
- mm_vector_input  out  DW*N  To datapath vector_input.
- mm_input_valid  out  1  To datapath input_valid.
- mm_vector_output  in  DW*N  From datapath vector_output.
- mm_add_valid  in  16  From datapath add_valid, one bit per lane.
- out_valid  out  1  Result valid.
- out_ready  in  1  Consumer ready.
- out_data  out  DW*N  Result vector.
- out_last  out  1  Final result of the command.
- busy  out  1  High whenever the state is not IDLE.
- done  out  1  One-cycle pulse at command completion.
- err_skew  out  1  Sticky lane-skew error flag.

Behaviour:
- Reset values: state IDLE, all counters 0, FIFO empty.
  - cmd_ready=1; in_ready=0; mm_input_valid=0; mm_vector_input=0.
  - out_valid=0; out_last=0; busy=0; done=0; err_skew=0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: on cmd_valid, latch cmd_count. Go to DONE if the count is 0, otherwise to ISSUE. Clear the issued, captured and popped counters.
  - ISSUE: in_ready = (issued < count) and (inflight + fifo_count < DEPTH), where inflight = issued - captured. When issued reaches count, go to DRAIN.
  - DRAIN: in_ready=0. When popped reaches count, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Issue timing: an input handshake registers in_data into mm_vector_input and sets mm_input_valid=1 on the next cycle.
  - mm_input_valid is 0 in every cycle without a handshake.
  - mm_vector_input holds its last value when no handshake occurs.
- Capture: in any non-IDLE cycle where mm_add_valid == 16'hFFFF, write mm_vector_output into the FIFO and increment captured.
  - The credit rule guarantees the FIFO is never full at a capture.
- Skew: if mm_add_valid is nonzero and not all-ones, set err_skew (sticky) and do not capture. Only reset clears err_skew.
- Stray results: mm_add_valid observed in IDLE is ignored and not flagged.
- Output:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - Pop on out_valid && out_ready, and increment popped.
  - out_last = out_valid and (popped == count-1).
- Simultaneous events:
  - A push and a pop in the same cycle leave fifo_count unchanged. This holds at both empty and full.
  - A capture and an issue in the same cycle are legal; inflight is updated by both.
- Latency: minimum of 1 cycle from FIFO write to out_valid, plus the datapath latency.
- Counters: issued, captured and popped are CW bits wide. Comparisons are unsigned, with no wrap within a command.
- Count 0: IDLE → DONE → IDLE, with done pulsing 2 cycles after the command handshake and no input accepted.
- Reset mid-operation: all state clears asynchronously and the FIFO contents are discarded. Datapath results arriving afterwards land in IDLE and are ignored.

Test Plan:
- cmd_count=4, in_valid held high, out_ready=1, datapath latency 5:
  - Exactly 4 mm_input_valid pulses.
  - 4 results in order; out_last on the 4th only.
  - done pulses once; busy falls on the same cycle as done.
- cmd_count=20, DEPTH=8, out_ready=0 until 30 cycles have elapsed:
  - in_ready drops after 8 issues.
  - No FIFO overflow.
  - All 20 results arrive in order after out_ready rises.
- cmd_count=0 → done 2 cycles after the command handshake; in_ready never high; no outputs.
- Inject mm_add_valid=16'h7FFF for one cycle during ISSUE → err_skew=1 and stays 1 through the next command; no capture that cycle.
- Assert rst_n=0 mid-DRAIN with 3 entries in the FIFO → all outputs return to reset values immediately.
  - Late mm_add_valid=16'hFFFF in IDLE is ignored.
  - cmd_ready=1.
- Random out_ready at 50% and random in_valid, cmd_count=100 → scoreboard matches 100 results, with out_last exactly once.
